set_sequencer: RTL

//  Frame-level sequencer between the memory arbiter, template/window handlers and NCC core.
//  Per set: fetch template, fetch window, wait for the NCC result, write back WB_WORDS words.

---
 rtl/set_sequencer_if.sv | 26 ++
 rtl/set_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/set_sequencer_if.sv
// Memory-side bus of the set sequencer: muxed read address, write-back word
// and the arbiter grant.
interface set_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7,
    parameter int WI_W   = 2
);
    logic              req;
    logic              rd_wr;
    logic              tem_win;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [DATA_W-1:0] write_data;
    logic [WI_W-1:0]   wr_index;
    logic              mem_gnt;

    modport master (
        output req, rd_wr, tem_win, row, col, write_data, wr_index,
        input  mem_gnt
    );

    modport slave (
        input  req, rd_wr, tem_win, row, col, write_data, wr_index,
        output mem_gnt
    );
endinterface

// File: rtl/set_sequencer.sv
// Frame sequencer: template fetch, window fetch, NCC result wait and
// write-back, repeated for every set of a frame.
module set_sequencer #(
    parameter int SETS_PER_FRAME = 150,
    parameter int WB_WORDS       = 3,
    parameter int DATA_W         = 32,
    parameter int IDX_W          = 7,
    parameter int CNT_W          = 8,
    parameter int WI_W           = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [IDX_W-1:0]           tmpl_row_i,
    input  logic [IDX_W-1:0]           tmpl_col_i,
    input  logic                       tmpl_done_i,
    input  logic [IDX_W-1:0]           win_row_i,
    input  logic [IDX_W-1:0]           win_col_i,
    input  logic                       win_done_i,
    input  logic [WB_WORDS*DATA_W-1:0] result_i,
    input  logic                       result_valid_i,
    output logic                       tmpl_en_o,
    output logic                       win_en_o,
    output logic [CNT_W-1:0]           set_count_o,
    output logic                       set_done_o,
    output logic                       busy_o,
    set_sequencer_if.master            mem
);

    typedef enum logic [2:0] {
        IDLE, TEMP, WIND, RES, WRIT, NEXT, DONE
    } state_e;

    localparam logic [WI_W-1:0]  LAST_WI = WI_W'(WB_WORDS - 1);
    localparam logic [CNT_W-1:0] NSETS   = CNT_W'(SETS_PER_FRAME);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [WI_W-1:0]            wi_q, wi_d;
    logic [WB_WORDS*DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0]          word_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wi_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wi_q    <= wi_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < WB_WORDS; k++) begin
            if (wi_q == WI_W'(k)) word_sel = res_q[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wi_d           = wi_q;
        res_d          = res_q;
        mem.req        = 1'b0;
        mem.rd_wr      = 1'b0;
        mem.tem_win    = 1'b0;
        mem.row        = '0;
        mem.col        = '0;
        mem.write_data = '0;
        mem.wr_index   = wi_q;
        tmpl_en_o      = 1'b0;
        win_en_o       = 1'b0;
        set_done_o     = 1'b0;
        busy_o         = (state_q != IDLE);
        set_count_o    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = TEMP;
            end
            TEMP: begin
                mem.req   = 1'b1;
                tmpl_en_o = 1'b1;
                mem.row   = tmpl_row_i;
                mem.col   = tmpl_col_i;
                if (tmpl_done_i) state_d = WIND;
            end
            WIND: begin
                mem.req     = 1'b1;
                mem.tem_win = 1'b1;
                win_en_o    = 1'b1;
                mem.row     = win_row_i;
                mem.col     = win_col_i;
                if (win_done_i) state_d = RES;
            end
            RES: begin
                if (result_valid_i) begin
                    res_d   = result_i;
                    wi_d    = '0;
                    state_d = WRIT;
                end
            end
            WRIT: begin
                mem.req        = 1'b1;
                mem.rd_wr      = 1'b1;
                mem.write_data = word_sel;
                if (mem.mem_gnt) begin
                    if (wi_q == LAST_WI) begin
                        // index wraps so it reads 0 outside write-back
                        wi_d    = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = NEXT;
                    end else begin
                        wi_d = wi_q + WI_W'(1);
                    end
                end
            end
            NEXT: begin
                state_d = (cnt_q == NSETS) ? DONE : TEMP;
            end
            DONE: begin
                set_done_o = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            wi_d    = '0;
        end
    end

endmodule
